// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: single-beat request (valid/ready) and valid-only response.
// One request may be outstanding; the response arrives at least one cycle after acceptance.
interface if_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/if_stage.sv
// Fetch stage + IF/ID register: handshake in N, response in N+1, instruction on id_* in N+2.
// Stall holds IF/ID and parks one response in a skid buffer; decode redirect flushes and drops stale data.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  if_stage_if.master       imem,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic             id_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;
  logic        drop, drop_nxt;
  logic [31:0] id_pc_nxt, id_inst_nxt;
  logic        id_valid_nxt;

  logic        redirect;
  logic        can_load;
  logic        accepted;
  logic        req_valid_st;
  logic        hs;
  logic        unused_addr_bits;

  assign redirect = branch_taken & ~stall;
  assign can_load = ~stall;
  assign accepted = (state == S_WAIT) & imem.imem_resp_valid & ~drop & ~redirect & can_load;

  // Next request goes out in the same cycle a response is consumed, giving one fetch per cycle.
  always_comb begin
    req_valid_st = 1'b0;
    case (state)
      S_REQ:   req_valid_st = 1'b1;
      S_WAIT:  req_valid_st = accepted;
      default: req_valid_st = 1'b0;
    endcase
  end

  assign imem.imem_req_valid = rst & req_valid_st;
  assign imem.imem_req_addr  = pc_q;
  assign hs                  = imem.imem_req_valid & imem.imem_req_ready;
  assign unused_addr_bits    = ^branch_addr[1:0];

  always_comb begin
    state_nxt    = state;
    pc_nxt       = hs ? pc_q + 32'd4 : pc_q;
    req_pc_nxt   = hs ? pc_q : req_pc;
    drop_nxt     = drop;
    buf_pc_nxt   = buf_pc;
    buf_inst_nxt = buf_inst;
    id_pc_nxt    = id_pc;
    id_inst_nxt  = NOP_INST;
    id_valid_nxt = 1'b0;

    case (state)
      S_REQ: begin
        if (hs) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else if (accepted) begin
            id_pc_nxt    = req_pc;
            id_inst_nxt  = imem.imem_resp_data;
            id_valid_nxt = 1'b1;
            state_nxt    = hs ? S_WAIT : S_REQ;
          end else if (stall) begin
            buf_pc_nxt   = req_pc;
            buf_inst_nxt = imem.imem_resp_data;
            state_nxt    = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (can_load) begin
          id_pc_nxt    = buf_pc;
          id_inst_nxt  = buf_inst;
          id_valid_nxt = 1'b1;
          state_nxt    = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    // A request still in flight (or issued this very cycle) returns stale data that must be swallowed.
    if (redirect) begin
      pc_nxt       = {branch_addr[31:2], 2'b00};
      id_pc_nxt    = id_pc;
      id_inst_nxt  = NOP_INST;
      id_valid_nxt = 1'b0;
      state_nxt    = S_REQ;
      if (((state == S_WAIT) && !imem.imem_resp_valid) || hs) begin
        drop_nxt  = 1'b1;
        state_nxt = S_WAIT;
      end
    end

    if (stall) begin
      id_pc_nxt    = id_pc;
      id_inst_nxt  = id_inst;
      id_valid_nxt = id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
      buf_pc   <= 32'h0;
      buf_inst <= NOP_INST;
      id_pc    <= 32'h0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      req_pc   <= req_pc_nxt;
      drop     <= drop_nxt;
      buf_pc   <= buf_pc_nxt;
      buf_inst <= buf_inst_nxt;
      id_pc    <= id_pc_nxt;
      id_inst  <= id_inst_nxt;
      id_valid <= id_valid_nxt;
    end
  end

endmodule
